sq_accum: RTL and testbench
===========================

Name: sq_accum

Overview:
- Downstream consumer of the 3-bit squarer's 6-bit output.
- Collects N square samples over a valid/ready handshake and produces their registered sum (sum of squares) with its own valid/ready handshake.
- Flags any input sample that is not a legal square of a 3-bit number.
- Sits between the squarer and any energy/statistics logic that needs a per-frame sum of squares.

Parameters:
- N, 8, number of samples per frame; legal range 2..64.
- ACC_W, 9, width of accumulator and sum output; must be >= 6 + clog2(N). Default holds 8*49 = 392.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous frame abort; clears frame state and err.
- sq_in  input  6  sample from the squarer.
- in_valid  input  1  sq_in is valid this cycle.
- in_ready  output  1  block can accept a sample.
- sum  output  ACC_W  sum of the N samples of the completed frame.
- out_valid  output  1  sum is valid.
- out_ready  input  1  consumer accepts sum.
- err  output  1  sticky flag: an accepted sample was not in {0,1,4,9,16,25,36,49}.

Behaviour:
- Reset: rst high asynchronously forces state=ACC, acc=0, cnt=0, sum=0, out_valid=0, err=0. in_ready is 1 once rst is low.
- Reset mid-frame: all partial accumulation is discarded. The first accepted sample after reset is sample 0 of a new frame.
- State ACC:
  - in_ready=1, out_valid=0.
  - Accept means in_valid & in_ready at a rising edge.
  - On accept with cnt < N-1: acc <= acc + sq_in (zero-extended to ACC_W); cnt <= cnt + 1.
  - On accept with cnt == N-1: sum <= acc + sq_in; acc <= 0; cnt <= 0; state <= HOLD.
  - in_valid low: no change.
- State HOLD:
  - in_ready=0, out_valid=1.
  - sum is stable and in_valid is ignored.
  - On out_ready high: state <= ACC; out_valid drops the next cycle. sum keeps its last value until overwritten.
  - out_ready low: hold indefinitely.
- Latency: out_valid rises on the clock edge that accepts sample N-1, so it is high in the cycle after that accept.
- Throughput: at most one frame per N+1 cycles; there is one dead cycle in HOLD with out_ready tied high.
- in_ready and out_valid are decoded from the state register only, with no combinational path from in_valid or out_ready.
- Arithmetic:
  - Unsigned addition with no saturation. ACC_W sizing guarantees no overflow for legal inputs.
  - Illegal inputs (up to 63*N) may wrap modulo 2^ACC_W; this is accepted behaviour, and err reports it.
- err:
  - Set on any accept whose sq_in is not a perfect square <= 49.
  - The sample is still accumulated.
  - Sticky until rst or clr.
- clr:
  - When high at an edge, takes priority over all other events: state <= ACC, acc <= 0, cnt <= 0, out_valid <= 0, err <= 0.
  - sum is unchanged.
  - A sample offered in the same cycle is dropped, even though in_ready was 1.
  - A pending sum in HOLD is discarded.
- Simultaneous events: rst over clr; clr over accept or out_ready.
- Assertions (bound property module, same style as the squarer's):
  - out_valid & in_ready is never true.
  - sum is stable while out_valid & !out_ready.
  - cnt < N always.

Test Plan:
- Frame of 0,1,4,9,16,25,36,49 with in_valid held high and out_ready=1 -> out_valid high for 1 cycle after the 8th accept, sum=140, err=0.
- Eight samples of 49 -> sum=392 (9'h188), no wrap.
- Frame of 1s with out_ready held low for 5 cycles after completion -> sum=8 stable, in_ready=0, in_valid pulses ignored. After out_ready=1, the next frame of eight 4s -> sum=32.
- Sample 6'd50 within an otherwise all-1 frame -> err=1 from the cycle after that accept, sum=57. err remains 1 through the next legal frame until clr is pulsed.
- Assert rst asynchronously (mid-cycle) after 3 accepted samples of 9 -> all outputs 0 immediately. A new frame of eight 1s -> sum=8, not 35.
- clr high in the same cycle as an accept of 16 at cnt=7 -> no out_valid, sample dropped, cnt=0. The next eight 0s -> sum=0.

Source files
------------

// File: rtl/sq_accum.sv
// Sum-of-squares frame accumulator: collects N samples from the 3-bit squarer
// and presents their registered sum over a valid/ready handshake.
module sq_accum #(
  parameter int N     = 8,
  parameter int ACC_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [5:0]       sq_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err
);

  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic {
    ACC,
    HOLD
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] sq_ext;
  logic             accept;
  logic             last;
  logic             legal;

  // Only squares of 0..7 can legally arrive from the upstream squarer.
  function automatic logic is_square(input logic [5:0] v);
    case (v)
      6'd0, 6'd1, 6'd4, 6'd9, 6'd16, 6'd25, 6'd36, 6'd49: is_square = 1'b1;
      default:                                           is_square = 1'b0;
    endcase
  endfunction

  assign sq_ext = ACC_W'(sq_in);
  assign accept = in_valid & in_ready;
  assign last   = (cnt == LAST);
  assign legal  = is_square(sq_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACC;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = ACC;
    end else begin
      unique case (state)
        ACC:     if (accept && last) state_nxt = HOLD;
        HOLD:    if (out_ready)      state_nxt = ACC;
        default: state_nxt = ACC;
      endcase
    end
  end

  // Handshake outputs come from the state register alone, keeping them free
  // of any combinational path from in_valid or out_ready.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      ACC:     in_ready  = 1'b1;
      HOLD:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // clr wipes the partial frame and err but deliberately leaves sum alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      sum <= '0;
      err <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      cnt <= '0;
      err <= 1'b0;
    end else if (accept) begin
      if (!legal) err <= 1'b1;
      if (last) begin
        sum <= acc + sq_ext;
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= acc + sq_ext;
        cnt <= cnt + 1'b1;
      end
    end
  end

  a_no_overlap : assert property (@(posedge clk) disable iff (rst)
    !(out_valid && in_ready));

  a_sum_stable : assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> $stable(sum));

  a_cnt_range : assert property (@(posedge clk) disable iff (rst)
    32'(cnt) < N);

endmodule

// File: tb/tb_sq_accum.sv
// Directed bench for sq_accum: a small frame model pushes expected sums to a
// scoreboard queue that is checked whenever the DUT presents a sum.
module tb_sq_accum;

  localparam int N     = 8;
  localparam int ACC_W = 9;

  logic             clk;
  logic             rst;
  logic             clr;
  logic [5:0]       sq_in;
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] sum;
  logic             out_valid;
  logic             out_ready;
  logic             err;

  int tests;
  int fails;

  logic [ACC_W-1:0] exp_q[$];
  logic             m_hold;
  logic             m_err;
  int               m_cnt;
  int               m_acc;

  sq_accum #(.N(N), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .sq_in     (sq_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic legal_sample(input logic [5:0] v);
    return v inside {6'd0, 6'd1, 6'd4, 6'd9, 6'd16, 6'd25, 6'd36, 6'd49};
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkVal("in_ready", {31'b0, in_ready}, {31'b0, ~m_hold});
    checkVal("out_valid", {31'b0, out_valid}, {31'b0, m_hold});
    checkVal("err", {31'b0, err}, {31'b0, m_err});
    if (m_hold) begin
      tests++;
      assert (exp_q.size() > 0) else begin
        fails++;
        $error("[TB] FAIL scoreboard_empty observed=%0d expected=%0d", exp_q.size(), 1);
      end
      if (exp_q.size() > 0) checkVal("sum_scoreboard", 32'(sum), 32'(exp_q[0]));
    end
  endtask

  task automatic resetModel();
    m_hold = 1'b0;
    m_err  = 1'b0;
    m_cnt  = 0;
    m_acc  = 0;
    exp_q.delete();
  endtask

  // One clock edge with the given inputs, then update the model and compare.
  task automatic step(input logic valid, input logic [5:0] v, input logic do_clr);
    logic prev_hold;
    prev_hold = m_hold;
    sq_in    = v;
    in_valid = valid;
    clr      = do_clr;
    @(posedge clk);
    #1;
    if (do_clr) begin
      resetModel();
    end else if (prev_hold) begin
      if (out_ready) begin
        m_hold = 1'b0;
        void'(exp_q.pop_front());
      end
    end else if (valid) begin
      if (!legal_sample(v)) m_err = 1'b1;
      if (m_cnt == N - 1) begin
        exp_q.push_back(ACC_W'(m_acc + int'(v)));
        m_acc  = 0;
        m_cnt  = 0;
        m_hold = 1'b1;
      end else begin
        m_acc = m_acc + int'(v);
        m_cnt = m_cnt + 1;
      end
    end
    in_valid = 1'b0;
    clr      = 1'b0;
    checkOutput();
  endtask

  task automatic applyStimulus(input logic [5:0] v, input logic do_clr = 1'b0);
    step(1'b1, v, do_clr);
  endtask

  task automatic idleCycle(input logic do_clr = 1'b0);
    step(1'b0, 6'd0, do_clr);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    resetModel();
    rst       = 1'b1;
    clr       = 1'b0;
    sq_in     = 6'd0;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    #1;
    checkVal("reset_sum", 32'(sum), 32'd0);
    checkVal("reset_out_valid", {31'b0, out_valid}, 32'd0);
    checkVal("reset_err", {31'b0, err}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idleCycle();

    // Every legal square once, in_valid held high.
    for (int i = 0; i < 8; i++) applyStimulus(6'(i * i));
    checkVal("t1_sum", 32'(sum), 32'd140);
    idleCycle();
    checkVal("t1_one_cycle", {31'b0, out_valid}, 32'd0);

    // Largest legal frame must not wrap.
    for (int i = 0; i < 8; i++) applyStimulus(6'd49);
    checkVal("t2_sum", 32'(sum), 32'h188);
    idleCycle();

    // Backpressure: sum held, offered samples ignored.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus(6'd1);
    for (int i = 0; i < 5; i++) applyStimulus(6'd4);
    checkVal("t3_hold_sum", 32'(sum), 32'd8);
    out_ready = 1'b1;
    idleCycle();
    for (int i = 0; i < 8; i++) applyStimulus(6'd4);
    checkVal("t3_sum", 32'(sum), 32'd32);
    idleCycle();

    // Illegal sample sets sticky err; clr clears it.
    for (int i = 0; i < 8; i++) applyStimulus((i == 3) ? 6'd50 : 6'd1);
    checkVal("t4_sum", 32'(sum), 32'd57);
    checkVal("t4_err", {31'b0, err}, 32'd1);
    idleCycle();
    for (int i = 0; i < 8; i++) applyStimulus(6'd1);
    checkVal("t4_err_sticky", {31'b0, err}, 32'd1);
    idleCycle();
    idleCycle(1'b1);
    checkVal("t4_err_cleared", {31'b0, err}, 32'd0);

    // Asynchronous reset mid-frame.
    for (int i = 0; i < 3; i++) applyStimulus(6'd9);
    #2;
    rst = 1'b1;
    #1;
    checkVal("t5_async_sum", 32'(sum), 32'd0);
    checkVal("t5_async_out_valid", {31'b0, out_valid}, 32'd0);
    checkVal("t5_async_err", {31'b0, err}, 32'd0);
    resetModel();
    #3;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus(6'd1);
    checkVal("t5_sum", 32'(sum), 32'd8);
    idleCycle();

    // clr collides with the final accept of a frame.
    for (int i = 0; i < 7; i++) applyStimulus(6'd16);
    applyStimulus(6'd16, 1'b1);
    checkVal("t6_no_out_valid", {31'b0, out_valid}, 32'd0);
    checkVal("t6_sum_kept", 32'(sum), 32'd8);
    for (int i = 0; i < 8; i++) applyStimulus(6'd0);
    checkVal("t6_sum", 32'(sum), 32'd0);
    idleCycle();
    idleCycle();

    checkVal("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
